stage_sequencer: RTL
====================

Name: stage_sequencer

Overview:
- Parametrised one-hot stage sequencer for the multicycle CPU.
- Generalises the fixed 5-stage IF/ID/EXE/MEM/WB counter to N stages.
- Adds per-instruction stage skipping, stall hold, abort-to-fetch, and an instruction-boundary halt/resume handshake.
- Sits between the control unit, which supplies the skip mask and the stall/abort/halt requests, and the datapath register enables, which consume Stage.

Parameters:
- NUM_STAGES, 5, number of stages. Legal range 3..16. Bit NUM_STAGES-1 = fetch, bit NUM_STAGES-2 = decode, lower bits = optional stages, executed in descending bit order.

Ports:
- CLK_in  input  1  clock; all state updates on rising edge.
- RST_in  input  1  synchronous, active-high reset.
- StageControl  input  NUM_STAGES-2  skip mask; bit j=1 means stage j is executed for the current instruction. Sampled live every cycle.
- Stall_in  input  1  hold the current stage.
- Abort_in  input  1  terminate the current instruction; next stage is fetch.
- Halt_in  input  1  halt request; honoured at the next instruction boundary.
- Resume_in  input  1  leave the halted state.
- Stage  output  NUM_STAGES  one-hot current stage, registered.
- Halted  output  1  processor halted; Stage is held at fetch.
- InstrDone  output  1  one-cycle pulse: an instruction completed normally.

Behaviour:
- Reset (RST_in=1 at an edge):
  - Stage = fetch one-hot (1<<(NUM_STAGES-1)).
  - Halted = 0, InstrDone = 0, pending-halt flag cleared.
  - Reset overrides every other input, including mid-instruction.
- Next-stage function from current stage bit k:
  - k = fetch → decode, unconditionally; mask is ignored.
  - k ≤ decode → the highest j < k with StageControl[j]=1. If no such j, wrap to fetch.
  - Stage 0 always wraps to fetch.
  - With NUM_STAGES=5 this matches the existing IF→ID→{EXE,MEM,WB}→IF flow.
- Per-edge priority, highest first: RST_in > Abort_in > Stall_in > Halted hold > normal advance.
- Abort_in=1 (not halted):
  - Next Stage = fetch; InstrDone stays 0.
  - Counts as an instruction boundary for halt.
  - Abort while already in fetch keeps fetch.
- Stall_in=1: Stage, Halted and the pending flag are unchanged; InstrDone = 0. Halt_in during a stall still sets the pending flag.
- Normal advance, non-fetch stage wrapping to fetch: InstrDone = 1 in the cycle Stage becomes fetch; otherwise InstrDone = 0.
- Halt handshake:
  - Halt_in=1 in any non-halted cycle sets the pending flag.
  - At an instruction boundary (any transition into fetch) with pending or Halt_in set: Halted = 1 together with Stage = fetch, and the pending flag clears.
  - Halt_in while Stage=fetch and not stalled: Stage stays fetch, Halted = 1 next cycle, no advance to decode.
  - While Halted: Stage held at fetch; StageControl, Stall_in and Abort_in are ignored.
  - Resume_in=1 while Halted: Halted = 0 next cycle, Stage still fetch. Decode follows on the next edge.
  - Resume_in and Halt_in together while halted: stay halted.
  - Resume_in when not halted: ignored.
- Stage is always exactly one-hot. No illegal state is reachable; any non-one-hot value recovers to fetch on the next edge.
- Latency: one cycle per stage. An instruction with m mask bits set takes 2+m cycles.

Optional Feature:
- Macro STAGE_SEQ_PERF_EN.
- Defined: adds outputs CycleCount[31:0] and InstrCount[31:0].
  - Both reset to 0.
  - CycleCount increments every non-halted cycle, including stalls.
  - InstrCount increments with each InstrDone pulse.
  - Both wrap modulo 2^32.
- Undefined: neither port nor counter exists; all other behaviour is identical.

Test Plan:
- NUM_STAGES=5, StageControl=3'b111, no requests, from reset → Stage sequence 10000, 01000, 00100, 00010, 00001, 10000; InstrDone=1 only in the last cycle.
- StageControl=3'b001 → 10000, 01000, 00001, 10000 (4 cycles). StageControl=3'b000 → 10000, 01000, 10000.
- In 00100, Stall_in=1 for 3 cycles → Stage holds 00100 for 4 cycles total, then 00010; no InstrDone during the stall.
- Halt_in pulsed during 00100 with mask 3'b111 → completes 00010, 00001; Stage=10000 with Halted=1 and InstrDone=1. Held 10 cycles; Resume_in → Halted=0, then 01000.
- Abort_in in 00010 → next Stage=10000, InstrDone=0. RST_in asserted during 00100 → Stage=10000, Halted=0 next edge.
- NUM_STAGES=8, StageControl=6'b101010 → 0x80, 0x40, 0x20, 0x08, 0x02, 0x80. With STAGE_SEQ_PERF_EN defined, InstrCount=1 and CycleCount=5 at the first wrap.

Source files
------------

// File: rtl/stage_sequencer_if.sv
// Bundle between the control unit and the stage sequencer.
// Ports: StageControl/Stall_in/Abort_in/Halt_in/Resume_in (requests), Stage/Halted/InstrDone (status).
// With STAGE_SEQ_PERF_EN defined, the bundle also carries the CycleCount/InstrCount counters.
interface stage_sequencer_if #(
   parameter int NUM_STAGES = 5
);
   logic [NUM_STAGES-3:0] StageControl;
   logic                  Stall_in;
   logic                  Abort_in;
   logic                  Halt_in;
   logic                  Resume_in;
   logic [NUM_STAGES-1:0] Stage;
   logic                  Halted;
   logic                  InstrDone;
`ifdef STAGE_SEQ_PERF_EN
   logic [31:0]           CycleCount;
   logic [31:0]           InstrCount;
`endif

   // Control unit side
   modport master (
      output StageControl, Stall_in, Abort_in, Halt_in, Resume_in,
      input  Stage, Halted, InstrDone
`ifdef STAGE_SEQ_PERF_EN
      , input CycleCount, InstrCount
`endif
   );

   // Sequencer side
   modport slave (
      input  StageControl, Stall_in, Abort_in, Halt_in, Resume_in,
      output Stage, Halted, InstrDone
`ifdef STAGE_SEQ_PERF_EN
      , output CycleCount, InstrCount
`endif
   );
endinterface

// File: rtl/stage_sequencer.sv
// One-hot N-stage instruction sequencer with skip mask, stall, abort and boundary halt/resume.
// Latency: one cycle per stage; Stage/Halted/InstrDone are registered, next stage follows each edge.
// Backpressure: Stall_in holds the current stage; a halted sequencer parks in fetch until Resume_in.
// Ports: CLK_in, RST_in (sync, active-high), sif = stage_sequencer_if.slave.
// Optional: define STAGE_SEQ_PERF_EN to add the CycleCount/InstrCount counters.
module stage_sequencer #(
   parameter int NUM_STAGES = 5
) (
   input logic               CLK_in,
   input logic               RST_in,
   stage_sequencer_if.slave  sif
);
   localparam int FETCH  = NUM_STAGES - 1;
   localparam int DECODE = NUM_STAGES - 2;
   localparam logic [NUM_STAGES-1:0] FETCH_OH  = {1'b1, {(NUM_STAGES-1){1'b0}}};
   localparam logic [NUM_STAGES-1:0] DECODE_OH = {2'b01, {(NUM_STAGES-2){1'b0}}};

   typedef enum logic {
      RUNNING = 1'b0,
      HALTED  = 1'b1
   } mode_t;

   mode_t                 mode;
   logic                  pending;
   logic                  halt_req;
   logic [NUM_STAGES-1:0] adv_stage;
   logic                  adv_wrap;

   assign halt_req   = pending | sif.Halt_in;
   assign sif.Halted = (mode == HALTED);

   // Next optional stage: highest enabled bit strictly below the current one.
   // Ascending scan lets a higher candidate overwrite a lower one.
   always_comb begin
      adv_stage = FETCH_OH;
      adv_wrap  = 1'b1;
      for (int k = 0; k < FETCH; k++) begin
         if (sif.Stage[k]) begin
            for (int j = 0; j < DECODE; j++) begin
               if (j < k && sif.StageControl[j]) begin
                  adv_stage    = '0;
                  adv_stage[j] = 1'b1;
                  adv_wrap     = 1'b0;
               end
            end
         end
      end
   end

   always_ff @(posedge CLK_in) begin
      if (RST_in) begin
         sif.Stage     <= FETCH_OH;
         sif.InstrDone <= 1'b0;
         mode          <= RUNNING;
         pending       <= 1'b0;
`ifdef STAGE_SEQ_PERF_EN
         sif.CycleCount <= '0;
         sif.InstrCount <= '0;
`endif
      end else begin
         sif.InstrDone <= 1'b0;
`ifdef STAGE_SEQ_PERF_EN
         if (mode == RUNNING) sif.CycleCount <= sif.CycleCount + 32'd1;
`endif
         case (mode)
            HALTED: begin
               // Parked in fetch; a simultaneous halt request keeps us parked.
               sif.Stage <= FETCH_OH;
               if (sif.Resume_in && !sif.Halt_in) mode <= RUNNING;
            end
            default: begin
               if (sif.Abort_in || !$onehot(sif.Stage)) begin
                  // Abort (or a corrupted stage vector) ends the instruction without completion.
                  sif.Stage <= FETCH_OH;
                  if (halt_req) begin
                     mode    <= HALTED;
                     pending <= 1'b0;
                  end
               end else if (sif.Stall_in) begin
                  pending <= halt_req;
               end else if (sif.Stage[FETCH]) begin
                  // Fetch is itself a boundary: a halt request parks here instead of decoding.
                  if (halt_req) begin
                     mode    <= HALTED;
                     pending <= 1'b0;
                  end else begin
                     sif.Stage <= DECODE_OH;
                  end
               end else if (adv_wrap) begin
                  sif.Stage     <= FETCH_OH;
                  sif.InstrDone <= 1'b1;
`ifdef STAGE_SEQ_PERF_EN
                  sif.InstrCount <= sif.InstrCount + 32'd1;
`endif
                  if (halt_req) begin
                     mode    <= HALTED;
                     pending <= 1'b0;
                  end
               end else begin
                  sif.Stage <= adv_stage;
                  pending   <= halt_req;
               end
            end
         endcase
      end
   end
endmodule
